// File: rtl/player_input_ctrl.sv
// ---------------------------------------------------------------------------
// player_input_ctrl
//   Upstream control stage of the player sprite/missile renderer. Raw board
//   buttons are synchronized and debounced, the player column is stepped on a
//   free-running motion tick and clamped to the screen limits, and each
//   accepted shot toggles one bit of the missile launch-toggle vector,
//   round-robin, rate-limited by a cooldown.
//
//   Build option: define PLAYER_AUTOFIRE_EN to get continuous fire while the
//   debounced fire button is held (one shot every FIRE_COOLDOWN+1 cycles).
//   Without it, every shot needs a fresh rising edge of the fire button.
//
// Ports:
//   clk            system clock (pixel clock domain)
//   rst            asynchronous active-low reset
//   btn_left       raw left button (async, active-high)
//   btn_right      raw right button (async, active-high)
//   btn_fire       raw fire button (async, active-high)
//   game_en        1 = controls live, 0 = movement and firing frozen
//   btn_col[11:0]  player sprite left column
//   btn_missle_en  missile launch-toggle vector (one bit flips per shot)
//   fire_pulse     one-cycle strobe on each accepted shot
//   slot_idx[2:0]  slot the next shot will toggle
// ---------------------------------------------------------------------------
module player_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 315000,
  parameter int unsigned MOVE_TICK       = 250000,
  parameter int unsigned STEP            = 2,
  parameter int unsigned COL_MIN         = 0,
  parameter int unsigned COL_MAX         = 609,
  parameter int unsigned COL_INIT        = 305,
  parameter int unsigned FIRE_COOLDOWN   = 7250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        game_en,
  output logic [11:0] btn_col,
  output logic [7:0]  btn_missle_en,
  output logic        fire_pulse,
  output logic [2:0]  slot_idx
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TK_W = $clog2(MOVE_TICK + 1);
  localparam int unsigned CD_W = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST  = TK_W'(MOVE_TICK - 1);
  localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(FIRE_COOLDOWN - 1);
  localparam logic [11:0]     COL_LO   = 12'(COL_MIN);
  localparam logic [11:0]     COL_HI   = 12'(COL_MAX);
  localparam logic [11:0]     COL_RST  = 12'(COL_INIT);
  localparam logic [11:0]     STEP_12  = 12'(STEP);
  // Left clamps when a full step would cross COL_MIN; right likewise for COL_MAX.
  localparam logic [11:0]     LEFT_LIM = 12'(COL_MIN + STEP);
  localparam logic [11:0]     RGHT_LIM = 12'(COL_MAX - STEP);

  typedef enum logic {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } fire_st_e;

  // Button index: 0 = left, 1 = right, 2 = fire.
  logic [2:0]      raw_s;
  logic [2:0]      sync1_r;
  logic [2:0]      sync2_r;
  logic [2:0]      db_lvl_r;
  logic [DB_W-1:0] db_cnt_r [3];
  logic [TK_W-1:0] tick_cnt_r;
  logic            tick_s;
  logic [11:0]     col_nxt_s;
  logic            fire_prev_r;
  logic            fire_req_s;
  fire_st_e        st_r;
  fire_st_e        st_nxt_s;
  logic [CD_W-1:0] cd_r;
  logic [CD_W-1:0] cd_nxt_s;
  logic            shot_s;
  logic [7:0]      missle_nxt_s;
  logic [2:0]      slot_nxt_s;

  assign raw_s  = {btn_fire, btn_right, btn_left};
  assign tick_s = (tick_cnt_r == TK_LAST);

  // Two-flop synchronizer on each raw button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_lvl_r <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == db_lvl_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_lvl_r[i] <= ~db_lvl_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Free-running motion tick counter; the tick is the wrap cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TK_W'(1);
    end
  end

  // Next column: clamped step on a live tick, hold otherwise (both buttons = hold).
  always_comb begin
    col_nxt_s = btn_col;
    if (tick_s && game_en) begin
      case ({db_lvl_r[0], db_lvl_r[1]})
        2'b10: begin
          if (btn_col < LEFT_LIM) col_nxt_s = COL_LO;
          else                    col_nxt_s = btn_col - STEP_12;
        end
        2'b01: begin
          if (btn_col > RGHT_LIM) col_nxt_s = COL_HI;
          else                    col_nxt_s = btn_col + STEP_12;
        end
        default: col_nxt_s = btn_col;
      endcase
    end else begin
      col_nxt_s = btn_col;
    end
  end

  // Shot request: level-triggered with autofire, otherwise edge-triggered.
  always_comb begin
`ifdef PLAYER_AUTOFIRE_EN
    fire_req_s = db_lvl_r[2] & game_en;
`else
    fire_req_s = db_lvl_r[2] & ~fire_prev_r & game_en;
`endif
  end

  // Fire FSM state, cooldown counter and previous debounced fire level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_r        <= ST_READY;
      cd_r        <= '0;
      fire_prev_r <= 1'b0;
    end else begin
      st_r        <= st_nxt_s;
      cd_r        <= cd_nxt_s;
      fire_prev_r <= db_lvl_r[2];
    end
  end

  // Fire FSM next state; edges seen during COOLDOWN are simply dropped.
  always_comb begin
    st_nxt_s = st_r;
    cd_nxt_s = cd_r;
    shot_s   = 1'b0;
    case (st_r)
      ST_READY: begin
        if (fire_req_s) begin
          shot_s   = 1'b1;
          cd_nxt_s = CD_LOAD;
          st_nxt_s = ST_COOLDOWN;
        end else begin
          st_nxt_s = ST_READY;
        end
      end
      ST_COOLDOWN: begin
        if (cd_r == '0) st_nxt_s = ST_READY;
        else            cd_nxt_s = cd_r - CD_W'(1);
      end
      default: begin
        st_nxt_s = ST_READY;
        cd_nxt_s = '0;
      end
    endcase
  end

  // Fire FSM outputs: a shot flips the current slot bit and advances the slot.
  always_comb begin
    missle_nxt_s = btn_missle_en;
    slot_nxt_s   = slot_idx;
    if (shot_s) begin
      missle_nxt_s = btn_missle_en ^ (8'h01 << slot_idx);
      slot_nxt_s   = slot_idx + 3'd1;
    end else begin
      missle_nxt_s = btn_missle_en;
      slot_nxt_s   = slot_idx;
    end
  end

  // Registered outputs; the toggle vector is only ever cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_col       <= COL_RST;
      btn_missle_en <= 8'h00;
      fire_pulse    <= 1'b0;
      slot_idx      <= 3'd0;
    end else begin
      btn_col       <= col_nxt_s;
      btn_missle_en <= missle_nxt_s;
      fire_pulse    <= shot_s;
      slot_idx      <= slot_nxt_s;
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_input_ctrl
//   Directed bench for player_input_ctrl with short timing parameters.
//   Three instances: the main one (COL_INIT=305) plus two edge instances
//   starting next to the left (COL_INIT=1) and right (COL_INIT=608) limits.
// ---------------------------------------------------------------------------
module tb_player_input_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned MT  = 8;
  localparam int unsigned STP = 2;
  localparam int unsigned CD  = 20;

  logic        clk;
  logic        rst;
  logic        btn_left;
  logic        btn_right;
  logic        btn_fire;
  logic        game_en;
  logic [11:0] btn_col;
  logic [7:0]  btn_missle_en;
  logic        fire_pulse;
  logic [2:0]  slot_idx;

  logic [11:0] lo_col;
  logic [7:0]  lo_missle;
  logic        lo_pulse;
  logic [2:0]  lo_slot;
  logic [11:0] hi_col;
  logic [7:0]  hi_missle;
  logic        hi_pulse;
  logic [2:0]  hi_slot;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          pulse_cnt;
  int          pulse_q[$];
  logic [11:0] col_prev;
  logic [11:0] lo_max;
  logic [11:0] hi_max;
  logic [7:0]  exp_m;
  logic [2:0]  exp_s;
  logic [7:0]  press_tbl [9];

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(DB), .MOVE_TICK(MT), .STEP(STP), .COL_MIN(0),
    .COL_MAX(609), .COL_INIT(305), .FIRE_COOLDOWN(CD)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
    .btn_fire(btn_fire), .game_en(game_en), .btn_col(btn_col),
    .btn_missle_en(btn_missle_en), .fire_pulse(fire_pulse), .slot_idx(slot_idx)
  );

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(DB), .MOVE_TICK(MT), .STEP(STP), .COL_MIN(0),
    .COL_MAX(609), .COL_INIT(1), .FIRE_COOLDOWN(CD)
  ) u_lo (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(1'b0),
    .btn_fire(1'b0), .game_en(game_en), .btn_col(lo_col),
    .btn_missle_en(lo_missle), .fire_pulse(lo_pulse), .slot_idx(lo_slot)
  );

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(DB), .MOVE_TICK(MT), .STEP(STP), .COL_MIN(0),
    .COL_MAX(609), .COL_INIT(608), .FIRE_COOLDOWN(CD)
  ) u_hi (
    .clk(clk), .rst(rst), .btn_left(1'b0), .btn_right(btn_right),
    .btn_fire(1'b0), .game_en(game_en), .btn_col(hi_col),
    .btn_missle_en(hi_missle), .fire_pulse(hi_pulse), .slot_idx(hi_slot)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance n cycles, sampling on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (fire_pulse) begin
        pulse_cnt++;
        pulse_q.push_back(cyc);
      end
      if (btn_col != col_prev) begin
        check_eq("col_step", 32'((btn_col > col_prev) ? (btn_col - col_prev) : (col_prev - btn_col)), 32'(STP));
        col_prev = btn_col;
      end
      if (lo_col > lo_max) lo_max = lo_col;
      if (hi_col > hi_max) hi_max = hi_col;
    end
  endtask

  // Bench-side record of an expected accepted shot.
  task automatic expect_shot();
    exp_m = exp_m ^ (8'h01 << exp_s);
    exp_s = exp_s + 3'd1;
  endtask

  // Fire press of len cycles followed by gap idle cycles.
  task automatic press(input int len, input int gap);
    btn_fire = 1'b1;
    step(len);
    btn_fire = 1'b0;
    step(gap);
  endtask

  initial begin
    press_tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};
    n_vec = 0; n_err = 0; cyc = 0; pulse_cnt = 0;
    rst = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; game_en = 1'b1;
    col_prev = 12'd305; lo_max = 12'd1; hi_max = 12'd608;
    exp_m = 8'h00; exp_s = 3'd0;

    // Reset release, idle.
    step(3);
    rst = 1'b1;
    step(100);
    check_eq("rst_col",    32'(btn_col), 32'd305);
    check_eq("rst_missle", 32'(btn_missle_en), 32'h00);
    check_eq("rst_pulses", 32'(pulse_cnt), 32'd0);
    check_eq("rst_slot",   32'(slot_idx), 32'd0);
    check_eq("rst_lo_col", 32'(lo_col), 32'd1);
    check_eq("rst_hi_col", 32'(hi_col), 32'd608);

    // Glitch shorter than the debounce window.
    btn_left = 1'b1; step(3); btn_left = 1'b0; step(24);
    check_eq("glitch_col", 32'(btn_col), 32'd305);
    check_eq("glitch_lo",  32'(lo_col), 32'd1);

    // Left held 80 cycles -> exactly 10 ticks of -2.
    btn_left = 1'b1; step(80); btn_left = 1'b0; step(16);
    check_eq("left_col",   32'(btn_col), 32'd285);
    check_eq("lo_clamp",   32'(lo_col), 32'd0);
    check_eq("lo_nowrap",  32'(lo_max), 32'd1);

    // Right held 40 cycles -> 5 ticks of +2.
    btn_right = 1'b1; step(40); btn_right = 1'b0; step(16);
    check_eq("right_col",  32'(btn_col), 32'd295);
    check_eq("hi_clamp",   32'(hi_col), 32'd609);
    check_eq("hi_nowrap",  32'(hi_max), 32'd609);

    // Both held -> hold.
    btn_left = 1'b1; btn_right = 1'b1; step(40);
    btn_left = 1'b0; btn_right = 1'b0; step(16);
    check_eq("both_col",   32'(btn_col), 32'd295);
    check_eq("both_lo",    32'(lo_col), 32'd0);
    check_eq("both_hi",    32'(hi_col), 32'd609);

    // Nine spaced presses walk the round-robin slots.
    for (int k = 0; k < 9; k++) begin
      pulse_cnt = 0;
      press(12, 30);
      check_eq("press_pulses", 32'(pulse_cnt), 32'd1);
      check_eq("press_missle", 32'(btn_missle_en), 32'(press_tbl[k]));
      check_eq("press_slot",   32'(slot_idx), 32'((k + 1) % 8));
    end
    exp_m = 8'hFE; exp_s = 3'd1;

    // Second press inside cooldown is dropped.
    pulse_cnt = 0;
    press(5, 5);
    press(5, 40);
    expect_shot();
    check_eq("drop_pulses", 32'(pulse_cnt), 32'd1);
    check_eq("drop_missle", 32'(btn_missle_en), 32'(exp_m));
    check_eq("drop_slot",   32'(slot_idx), 32'(exp_s));

`ifndef PLAYER_AUTOFIRE_EN
    // Held button fires once; no refire on return to READY.
    pulse_cnt = 0;
    press(40, 30);
    expect_shot();
    check_eq("held_pulses", 32'(pulse_cnt), 32'd1);
    check_eq("held_missle", 32'(btn_missle_en), 32'(exp_m));
`endif

    // game_en low: no shot, no motion.
    pulse_cnt = 0;
    game_en = 1'b0;
    btn_left = 1'b1; btn_fire = 1'b1; step(24);
    btn_left = 1'b0; btn_fire = 1'b0; step(20);
    game_en = 1'b1;
    step(4);
    check_eq("frz_pulses", 32'(pulse_cnt), 32'd0);
    check_eq("frz_missle", 32'(btn_missle_en), 32'(exp_m));
    check_eq("frz_col",    32'(btn_col), 32'd295);

    // Reset asserted mid-cooldown acts without a clock edge.
    pulse_cnt = 0;
    btn_fire = 1'b1; step(9); btn_fire = 1'b0;
    expect_shot();
    check_eq("pre_rst_pulse",  32'(pulse_cnt), 32'd1);
    check_eq("pre_rst_missle", 32'(btn_missle_en), 32'(exp_m));
    #1 rst = 1'b0;
    #1;
    check_eq("async_col",    32'(btn_col), 32'd305);
    check_eq("async_missle", 32'(btn_missle_en), 32'h00);
    check_eq("async_pulse",  32'(fire_pulse), 32'd0);
    check_eq("async_slot",   32'(slot_idx), 32'd0);
    col_prev = 12'd305;
    step(2);
    rst = 1'b1;
    exp_m = 8'h00; exp_s = 3'd0;
    step(3);

    // Cooldown was aborted: an immediate press is accepted.
    pulse_cnt = 0;
    press(12, 30);
    expect_shot();
    check_eq("post_rst_pulses", 32'(pulse_cnt), 32'd1);
    check_eq("post_rst_missle", 32'(btn_missle_en), 32'(exp_m));
    check_eq("post_rst_slot",   32'(slot_idx), 32'(exp_s));

`ifdef PLAYER_AUTOFIRE_EN
    // Autofire: held fire gives a shot every FIRE_COOLDOWN+1 cycles.
    pulse_cnt = 0;
    pulse_q.delete();
    press(100, 30);
    check_eq("auto_pulses", 32'(pulse_cnt), 32'd5);
    for (int i = 1; i < pulse_q.size(); i++)
      check_eq("auto_period", 32'(pulse_q[i] - pulse_q[i-1]), 32'(CD + 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
